stream_recv: RTL and testbench
==============================

# stream_recv

Input-side stream controller: AXI-Stream-style slave that accepts the host's data burst into the local core buffer. Sits between the DMA source port and the buffer write port, mirroring the output controller that drains results back out. Accepts words while armed, writes each into sequential buffer addresses with one cycle of latency, and reports completion and length to the control logic. Bursts that overrun the buffer are drained and flagged.

## Interface
Parameters:
- DW, 32, stream/buffer data width
- AW, 10, buffer address width (depth 2^AW words)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- run  in  1  one-cycle arm pulse; honoured only in IDLE
- src_valid  in  1  source word valid
- src_data  in  DW  source word
- src_last  in  1  final word of burst
- src_ready  out  1  accept; combinational from state only
- mem_we  out  1  buffer write enable (registered)
- mem_addr  out  AW  buffer write address (registered)
- mem_wdata  out  DW  buffer write data (registered)
- recv_fin  out  1  one-cycle completion pulse
- recv_len  out  AW+1  words written in last burst; valid from recv_fin until next run
- recv_err  out  1  overrun flag; sticky until next run

## Operation
- States: IDLE, RECV, DRAIN, DONE.
- Handshake hs = src_valid & src_ready. src_ready = 1 in RECV and DRAIN, else 0. Never depends on src_valid.
- IDLE: run -> RECV; clears address counter, recv_len, recv_err.
- RECV, per hs: mem_we<=1, mem_addr<=cnt, mem_wdata<=src_data, cnt<=cnt+1.
  - hs & src_last -> DONE.
  - hs & ~src_last & cnt==2^AW-1 (buffer just filled) -> DRAIN, recv_err<=1.
- DRAIN: hs accepted but not written (mem_we=0); hs & src_last -> DONE.
- DONE: recv_fin=1 for exactly one cycle, recv_len=cnt (2^AW on full buffer, hence AW+1 bits), -> IDLE.
- Last word landing exactly in address 2^AW-1 with src_last=1: normal completion, recv_err=0, recv_len=2^AW.
- run while not IDLE: ignored. run in DONE cycle: ignored.
- src_valid in IDLE/DONE: not accepted; source holds data (standard valid-hold rule).
- cnt is AW+1 bits; never wraps within a burst.

## Timing
- Reset (async assert): state IDLE, src_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, recv_fin=0, recv_len=0, recv_err=0, cnt=0.
- run at cycle t -> src_ready=1 at t+1.
- hs at cycle t -> mem_we/addr/wdata visible t+1; back-to-back hs gives one write per cycle, full throughput.
- Last hs at t -> final write at t+1 and recv_fin=1 at t+1 (same cycle); src_ready=0 from t+1.
- Earliest re-arm: run at t+2 (IDLE).
- Reset mid-burst: all outputs to reset values immediately; partial burst discarded, no recv_fin.

## Structure
- Shared package stream_pkg: state enum (IDLE, RECV, DRAIN, DONE), default DW/AW constants.
- Natural sub-module: recv_addr_cnt — clearable AW+1-bit counter with enable, exposing count and full-compare (cnt==2^AW-1); instantiated once.
- Outputs registered except src_ready (decode of state register).

## Test plan
- AW=3, run, 4-word burst 0xA0..0xA3 with last on 0xA3, src_valid held -> writes addr 0..3 on consecutive cycles, recv_fin one cycle with final write, recv_len=4, recv_err=0.
- AW=3, 8-word burst, last on 8th -> addr 0..7 written, recv_len=8, recv_err=0.
- AW=3, 11-word burst -> 8 writes, then 3 words accepted with mem_we=0, recv_fin after 11th, recv_len=8, recv_err=1.
- Random src_valid gaps (≈50%) over 5 words -> writes only on hs cycles, data/addr order preserved, recv_len=5.
- src_valid=1 before run, plus run pulses during RECV -> no hs before arming, extra run has no effect, single recv_fin.
- Async rst asserted after 2 of 4 words -> outputs reset within the cycle, no recv_fin; new run + 1-word burst -> addr 0 written, recv_len=1.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared definitions for the stream input/output controllers.
package stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_DW = 32;
    localparam int DEF_AW = 10;

endpackage

// File: rtl/recv_addr_cnt.sv
// Clearable AW+1-bit write-address counter with buffer-full compare.
module recv_addr_cnt #(
    parameter int AW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    output logic [AW:0] cnt,
    output logic        full
);

    logic [AW:0] cnt_q;
    logic [AW:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    // Last addressable word; the extra MSB lets a full buffer report 2^AW.
    assign full = (cnt_q == {1'b0, {AW{1'b1}}});

endmodule

// File: rtl/stream_recv.sv
// Stream slave: writes an incoming burst into sequential buffer addresses,
// drains and flags bursts longer than the buffer.
module stream_recv
    import stream_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          src_valid,
    input  logic [DW-1:0] src_data,
    input  logic          src_last,
    output logic          src_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          recv_fin,
    output logic [AW:0]   recv_len,
    output logic          recv_err
);

    state_t        state_q, state_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          recv_fin_q, recv_fin_d;
    logic [AW:0]   recv_len_q, recv_len_d;
    logic          recv_err_q, recv_err_d;

    logic          cnt_clr;
    logic          cnt_en;
    logic [AW:0]   cnt;
    logic          cnt_full;
    logic          hs;

    recv_addr_cnt #(.AW(AW)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .cnt  (cnt),
        .full (cnt_full)
    );

    assign src_ready = (state_q == ST_RECV) || (state_q == ST_DRAIN);
    assign hs        = src_valid & src_ready;

    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        recv_fin_d  = 1'b0;
        recv_len_d  = recv_len_q;
        recv_err_d  = recv_err_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d    = ST_RECV;
                    cnt_clr    = 1'b1;
                    recv_len_d = '0;
                    recv_err_d = 1'b0;
                end
            end
            ST_RECV: begin
                if (hs) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt[AW-1:0];
                    mem_wdata_d = src_data;
                    cnt_en      = 1'b1;
                    if (src_last) begin
                        state_d    = ST_DONE;
                        recv_fin_d = 1'b1;
                        // Length includes the word being written this cycle.
                        recv_len_d = cnt + (AW+1)'(1);
                    end else if (cnt_full) begin
                        state_d    = ST_DRAIN;
                        recv_err_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (hs && src_last) begin
                    state_d    = ST_DONE;
                    recv_fin_d = 1'b1;
                    recv_len_d = cnt;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            recv_fin_q  <= 1'b0;
            recv_len_q  <= '0;
            recv_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            recv_fin_q  <= recv_fin_d;
            recv_len_q  <= recv_len_d;
            recv_err_q  <= recv_err_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign recv_fin  = recv_fin_q;
    assign recv_len  = recv_len_q;
    assign recv_err  = recv_err_q;

endmodule

// File: tb/tb_stream_recv.sv
// Randomized bench for stream_recv against a burst-level reference model.
module tb_stream_recv;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          src_valid = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          src_last = 1'b0;
    logic          src_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          recv_fin;
    logic [AW:0]   recv_len;
    logic          recv_err;

    int checks   = 0;
    int failures = 0;
    int we_cnt   = 0;
    int fin_cnt  = 0;
    bit noise_run = 1'b0;

    stream_recv #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_last  (src_last),
        .src_ready (src_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .recv_fin  (recv_fin),
        .recv_len  (recv_len),
        .recv_err  (recv_err)
    );

    always #5 clk = ~clk;

    // Reference model: a burst is a count of accepted words; the first DEPTH
    // land at addresses 0..DEPTH-1, the rest are dropped and flag an overrun.
    bit            m_acc;
    bit            m_done;
    int            m_n;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic          exp_fin;
    logic [AW:0]   exp_len;
    logic          exp_err;
    logic          exp_ready;

    assign exp_ready = m_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_acc     <= 1'b0;
            m_done    <= 1'b0;
            m_n       <= 0;
            exp_we    <= 1'b0;
            exp_addr  <= '0;
            exp_wdata <= '0;
            exp_fin   <= 1'b0;
            exp_len   <= '0;
            exp_err   <= 1'b0;
        end else begin
            exp_we  <= 1'b0;
            exp_fin <= 1'b0;
            if (m_done) begin
                m_done <= 1'b0;
            end else if (!m_acc) begin
                if (run) begin
                    m_acc   <= 1'b1;
                    m_n     <= 0;
                    exp_len <= '0;
                    exp_err <= 1'b0;
                end
            end else if (src_valid) begin
                if (m_n < DEPTH) begin
                    exp_we    <= 1'b1;
                    exp_addr  <= m_n[AW-1:0];
                    exp_wdata <= src_data;
                end
                m_n <= m_n + 1;
                if (src_last) begin
                    m_acc   <= 1'b0;
                    m_done  <= 1'b1;
                    exp_fin <= 1'b1;
                    exp_len <= (AW+1)'((m_n + 1 > DEPTH) ? DEPTH : m_n + 1);
                end else if (m_n + 1 == DEPTH) begin
                    exp_err <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("src_ready", 64'(src_ready), 64'(exp_ready));
            chk("mem_we",    64'(mem_we),    64'(exp_we));
            chk("mem_addr",  64'(mem_addr),  64'(exp_addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
            chk("recv_fin",  64'(recv_fin),  64'(exp_fin));
            chk("recv_len",  64'(recv_len),  64'(exp_len));
            chk("recv_err",  64'(recv_err),  64'(exp_err));
            if (mem_we)   we_cnt++;
            if (recv_fin) fin_cnt++;
        end
    end

    task automatic arm();
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
    endtask

    task automatic idle_wait();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        we_cnt  = 0;
        fin_cnt = 0;
    endtask

    // Presents words n of a total-word burst; valid, once raised, holds until accepted.
    task automatic send_burst(input int n, input int total, input logic [DW-1:0] base,
                              input int gap);
        int  i = 0;
        int  guard = 0;
        bit  acc;
        while (i < n) begin
            if (!src_valid && ($urandom_range(99) >= gap)) begin
                src_valid = 1'b1;
                src_data  = base + DW'(i);
                src_last  = (i == total - 1);
            end
            run = noise_run ? 1'($urandom_range(1)) : 1'b0;
            @(negedge clk);
            acc = src_valid && src_ready;
            @(posedge clk); #1;
            if (acc) begin
                i++;
                src_valid = 1'b0;
                src_last  = 1'b0;
            end
            guard++;
            if (guard > 500) begin
                checks++;
                failures++;
                $display("FAIL burst_timeout actual=%0d words required=%0d", i, n);
                break;
            end
        end
        run = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(src_ready), 64'd0);
        chk({tag, "_we"},    64'(mem_we),    64'd0);
        chk({tag, "_addr"},  64'(mem_addr),  64'd0);
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_fin"},   64'(recv_fin),  64'd0);
        chk({tag, "_len"},   64'(recv_len),  64'd0);
        chk({tag, "_err"},   64'(recv_err),  64'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        rst = 1'b0;
        @(posedge clk); #1;

        // 4-word burst, valid held.
        clear_counts();
        arm();
        send_burst(4, 4, 32'hA0, 0);
        idle_wait();
        chk("t1_len", 64'(recv_len), 64'd4);
        chk("t1_err", 64'(recv_err), 64'd0);
        chk("t1_we_cnt", 64'(we_cnt), 64'd4);
        chk("t1_fin_cnt", 64'(fin_cnt), 64'd1);
        chk("t1_last_addr", 64'(mem_addr), 64'd3);
        chk("t1_last_data", 64'(mem_wdata), 64'hA3);

        // Exactly fills the buffer.
        clear_counts();
        arm();
        send_burst(8, 8, 32'hB0, 0);
        idle_wait();
        chk("t2_len", 64'(recv_len), 64'd8);
        chk("t2_err", 64'(recv_err), 64'd0);
        chk("t2_we_cnt", 64'(we_cnt), 64'd8);

        // Overrun.
        clear_counts();
        arm();
        send_burst(11, 11, 32'hC0, 0);
        idle_wait();
        chk("t3_len", 64'(recv_len), 64'd8);
        chk("t3_err", 64'(recv_err), 64'd1);
        chk("t3_we_cnt", 64'(we_cnt), 64'd8);
        chk("t3_fin_cnt", 64'(fin_cnt), 64'd1);
        chk("t3_last_data", 64'(mem_wdata), 64'hC7);

        // Gappy source.
        clear_counts();
        arm();
        send_burst(5, 5, 32'hD0, 50);
        idle_wait();
        chk("t4_len", 64'(recv_len), 64'd5);
        chk("t4_we_cnt", 64'(we_cnt), 64'd5);

        // Valid before arming, stray run pulses mid-burst.
        clear_counts();
        src_valid = 1'b1;
        src_data  = 32'hE0;
        src_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        noise_run = 1'b1;
        arm();
        send_burst(6, 6, 32'hE0, 30);
        noise_run = 1'b0;
        idle_wait();
        chk("t5_fin_cnt", 64'(fin_cnt), 64'd1);
        chk("t5_len", 64'(recv_len), 64'd6);
        chk("t5_we_cnt", 64'(we_cnt), 64'd6);

        // Async reset mid-burst, then a 1-word burst.
        clear_counts();
        arm();
        send_burst(2, 4, 32'hF0, 0);
        src_valid = 1'b1;
        src_data  = 32'hF2;
        #1 rst = 1'b1;
        src_valid = 1'b0;
        #1;
        check_reset_outputs("rst1");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("t6_no_fin", 64'(fin_cnt), 64'd0);
        clear_counts();
        arm();
        send_burst(1, 1, 32'h55, 0);
        idle_wait();
        chk("t6_len", 64'(recv_len), 64'd1);
        chk("t6_addr", 64'(mem_addr), 64'd0);
        chk("t6_data", 64'(mem_wdata), 64'h55);
        chk("t6_we_cnt", 64'(we_cnt), 64'd1);

        // Random bursts; the model checks every cycle.
        for (int b = 0; b < 30; b++) begin
            int len;
            len = int'($urandom_range(12, 1));
            noise_run = 1'($urandom_range(1));
            if ($urandom_range(3) == 0) repeat (int'($urandom_range(3))) @(posedge clk);
            #1;
            arm();
            send_burst(len, len, DW'($urandom), int'($urandom_range(60)));
            noise_run = 1'b0;
            idle_wait();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
